// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises transactions from two requesters (A = CPU,
// B = loader/DMA) onto the single Hack memory bus. Round-robin between
// simultaneous requests, writes wait on mem_busy, reads are returned with a
// one-cycle ack pulse.
// Optional feature macro: MEM_ARB_WATCHDOG_EN -- drops a write that has been
// held off by mem_busy for WDOG_CYCLES cycles and raises a sticky wdog_err_o.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  a_req_i,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_wdata_i,
    output logic                  a_ack_o,
    output logic [DATA_WIDTH-1:0] a_rdata_o,
    input  logic                  b_req_i,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_wdata_i,
    output logic                  b_ack_o,
    output logic [DATA_WIDTH-1:0] b_rdata_o,
    output logic                  mem_load_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0] mem_in_o,
    input  logic                  mem_busy_i,
    input  logic [DATA_WIDTH-1:0] mem_out_i,
    output logic                  wdog_err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e                  state_q;
    logic                    owner_q;   // 0 = A, 1 = B
    logic                    last_q;    // requester granted most recently
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    a_ack_q;
    logic                    b_ack_q;
    logic [DATA_WIDTH-1:0]   a_rdata_q;
    logic [DATA_WIDTH-1:0]   b_rdata_q;

    logic                    any_req_d;
    logic                    grant_b_d;
    logic                    wdog_trip_d;
    logic                    issue_done_d;

    // B wins when it is the only requester, or when both request and A was
    // granted last time.
    assign any_req_d    = a_req_i | b_req_i;
    assign grant_b_d    = b_req_i & (~a_req_i | ~last_q);

    // A read leaves ISSUE unconditionally; a write leaves once memory accepts
    // it or the watchdog gives up on it.
    assign issue_done_d = (state_q == S_ISSUE) & (~we_q | ~mem_busy_i | wdog_trip_d);

`ifdef MEM_ARB_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_q;
    logic              wdog_err_q;

    // Trip on the WDOG_CYCLES-th consecutive busy cycle of a pending write.
    assign wdog_trip_d = (state_q == S_ISSUE) & we_q & mem_busy_i
                       & (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));

    // Count busy cycles while a write waits; the error flag is sticky.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if ((state_q == S_ISSUE) && we_q && mem_busy_i && !wdog_trip_d) begin
                wdog_cnt_q <= wdog_cnt_q + 1'b1;
            end else begin
                wdog_cnt_q <= '0;
            end
            if (wdog_trip_d) begin
                wdog_err_q <= 1'b1;
            end
        end
    end

    assign wdog_err_o = wdog_err_q;
`else
    logic unused_wdog_cfg;

    assign wdog_trip_d     = 1'b0;
    assign wdog_err_o      = 1'b0;
    assign unused_wdog_cfg = (WDOG_CYCLES > 0);
`endif

    // Arbitration / transaction sequencer with registered bus and ack outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_req_d) begin
                        owner_q <= grant_b_d;
                        we_q    <= grant_b_d ? b_we_i    : a_we_i;
                        addr_q  <= grant_b_d ? b_addr_i  : a_addr_i;
                        wdata_q <= grant_b_d ? b_wdata_i : a_wdata_i;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_done_d) begin
                        state_q <= S_RESP;
                        if (owner_q) begin
                            b_ack_q <= 1'b1;
                        end else begin
                            a_ack_q <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    last_q  <= owner_q;
                    if (!we_q) begin
                        if (owner_q) begin
                            b_rdata_q <= mem_out_i;
                        end else begin
                            a_rdata_q <= mem_out_i;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The write strobe must react to mem_busy in the same cycle, so it is a
    // gate of registered state and the live busy flag rather than a register.
    assign mem_load_o    = (state_q == S_ISSUE) & we_q & ~mem_busy_i;
    assign mem_address_o = addr_q;
    assign mem_in_o      = wdata_q;

    assign a_ack_o = a_ack_q;
    assign b_ack_o = b_ack_q;

    // Read data arrives from memory during the ack cycle; pass it straight
    // through then, and hold the value captured at the end of that cycle.
    assign a_rdata_o = (a_ack_q & ~we_q) ? mem_out_i : a_rdata_q;
    assign b_rdata_o = (b_ack_q & ~we_q) ? mem_out_i : b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: reset values, table-driven single
// transactions, back-to-back reads, random traffic against a map-based
// reference memory, round-robin contention and reset during a stalled write.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_req, a_we, a_ack;
    logic [15:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_we, b_ack;
    logic [15:0] b_addr, b_wdata, b_rdata;
    logic        mem_load, mem_busy, wdog_err;
    logic [15:0] mem_address, mem_in, mem_out;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16),
        .WDOG_CYCLES(1024)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .a_req_i      (a_req),
        .a_we_i       (a_we),
        .a_addr_i     (a_addr),
        .a_wdata_i    (a_wdata),
        .a_ack_o      (a_ack),
        .a_rdata_o    (a_rdata),
        .b_req_i      (b_req),
        .b_we_i       (b_we),
        .b_addr_i     (b_addr),
        .b_wdata_i    (b_wdata),
        .b_ack_o      (b_ack),
        .b_rdata_o    (b_rdata),
        .mem_load_o   (mem_load),
        .mem_address_o(mem_address),
        .mem_in_o     (mem_in),
        .mem_busy_i   (mem_busy),
        .mem_out_i    (mem_out),
        .wdog_err_o   (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory emulation: write on load, read data one cycle later.
    logic [15:0] mem_emu [0:65535];
    initial mem_out = 16'h0000;
    always @(posedge clk) begin
        if (mem_load) mem_emu[mem_address] <= mem_in;
        mem_out <= mem_emu[mem_address];
    end

    // Reference model: what each address should hold after completed writes.
    logic [15:0] ref_mem [int];

    function automatic logic [15:0] ref_rd(input logic [15:0] addr);
        if (ref_mem.exists(int'(addr))) return ref_mem[int'(addr)];
        return 16'h0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input bit p, input bit v, input bit we,
                           input logic [15:0] addr, input logic [15:0] wdata);
        if (!p) begin
            a_req = v; a_we = we; a_addr = addr; a_wdata = wdata;
        end else begin
            b_req = v; b_we = we; b_addr = addr; b_wdata = wdata;
        end
    endtask

    // One isolated transaction on port p; called just before an IDLE edge.
    task automatic run_txn(input bit p, input bit we, input logic [15:0] addr,
                           input logic [15:0] wdata, input int busy_n,
                           input int exp_lat, input logic [15:0] exp_rd);
        int          ack_c, load_c, loads;
        bit          held_ok, other_ack, busy_load;
        logic [15:0] rd, other_before;
        other_before = p ? a_rdata : b_rdata;
        ack_c = -1; load_c = -1; loads = 0;
        held_ok = 1'b1; other_ack = 1'b0; busy_load = 1'b0; rd = 16'h0;
        mem_busy = 1'b0;
        set_req(p, 1'b1, we, addr, wdata);
        for (int c = 1; c <= 60 && ack_c < 0; c++) begin
            @(posedge clk); #1;
            mem_busy = (c <= busy_n);
            @(negedge clk);
            if (mem_load) begin loads++; load_c = c; end
            if (mem_load && mem_busy) busy_load = 1'b1;
            if (mem_address !== addr || (we && mem_in !== wdata)) held_ok = 1'b0;
            if ((p ? a_ack : b_ack) === 1'b1) other_ack = 1'b1;
            if ((p ? b_ack : a_ack) === 1'b1) begin
                ack_c = c;
                rd = p ? b_rdata : a_rdata;
            end
        end
        @(posedge clk); #1;
        set_req(p, 1'b0, we, addr, wdata);
        mem_busy = 1'b0;
        @(negedge clk);
        check("ack_single_pulse", p ? b_ack : a_ack, 0);
        check("ack_latency", ack_c, exp_lat);
        check("load_count", loads, we ? 1 : 0);
        if (we) check("load_cycle", load_c, 1 + busy_n);
        check("bus_held", held_ok, 1);
        check("other_ack_quiet", other_ack, 0);
        check("load_while_busy", busy_load, 0);
        check("other_rdata_kept", p ? a_rdata : b_rdata, other_before);
        if (!we) check("rdata", rd, exp_rd);
        else     ref_mem[int'(addr)] = wdata;
        $display("txn %s %s addr=%04h wdata=%04h busy=%0d ack_cycle=%0d rdata=%04h",
                 p ? "B" : "A", we ? "WR" : "RD", addr, wdata, busy_n, ack_c, rd);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_load"}, mem_load, 0);
        check({tag, "_mem_address"}, mem_address, 0);
        check({tag, "_mem_in"}, mem_in, 0);
        check({tag, "_a_ack"}, a_ack, 0);
        check({tag, "_b_ack"}, b_ack, 0);
        check({tag, "_a_rdata"}, a_rdata, 0);
        check({tag, "_b_rdata"}, b_rdata, 0);
        check({tag, "_wdog_err"}, wdog_err, 0);
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          busy;
        int          exp_lat;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int          c1, c2, nack, bad;
        logic [15:0] r1, r2;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 0, 2, 16'h1234};
        vecs[1] = '{1'b1, 1'b1, 16'h4005, 16'hBEEF, 3, 5, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h4005, 16'h0000, 0, 2, 16'hBEEF};
        vecs[3] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 2, 2, 16'h0011};
        vecs[4] = '{1'b0, 1'b1, 16'h6000, 16'h0001, 0, 2, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 16'h6000, 16'h0000, 0, 2, 16'h0001};
        vecs[6] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 0, 2, 16'h0022};
        vecs[7] = '{1'b0, 1'b1, 16'h0002, 16'h5555, 1, 3, 16'h0000};
        vecs[8] = '{1'b1, 1'b0, 16'h0002, 16'h0000, 0, 2, 16'h5555};

        for (int i = 0; i < 65536; i++) mem_emu[i] = 16'h0000;
        mem_emu[16'h0010] = 16'h1234; ref_mem[16'h0010] = 16'h1234;
        mem_emu[16'h0001] = 16'h0011; ref_mem[16'h0001] = 16'h0011;
        mem_emu[16'h0002] = 16'h0022; ref_mem[16'h0002] = 16'h0022;

        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        mem_busy = 1'b0;

        // Reset values, during and just after reset.
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // Back-to-back A reads with req held across the first ack.
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000);
        c1 = -1; c2 = -1; nack = 0; r1 = 0; r2 = 0;
        for (int c = 1; c <= 30 && nack < 2; c++) begin
            @(posedge clk); #1;
            if (nack == 1 && c == c1 + 1) a_addr = 16'h0002;
            @(negedge clk);
            if (a_ack === 1'b1) begin
                if (nack == 0) begin c1 = c; r1 = a_rdata; end
                else           begin c2 = c; r2 = a_rdata; end
                nack++;
            end
        end
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        check("b2b_ack_count", nack, 2);
        check("b2b_first_ack", c1, 2);
        check("b2b_spacing", c2 - c1, 3);
        check("b2b_rdata1", r1, 16'h0011);
        check("b2b_rdata2", r2, 16'h0022);
        $display("txn A RD b2b acks at %0d,%0d rdata=%04h,%04h", c1, c2, r1, r2);

        // Table-driven single transactions.
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].busy, vecs[i].exp_lat, vecs[i].exp_rd);
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            bit          p, we;
            logic [15:0] addr, wdata;
            int          busy;
            p     = 1'($urandom_range(1, 0));
            we    = 1'($urandom_range(1, 0));
            addr  = 16'h0040 + 16'($urandom_range(7, 0));
            wdata = 16'($urandom);
            busy  = int'($urandom_range(3, 0));
            run_txn(p, we, addr, wdata, busy, we ? 2 + busy : 2, ref_rd(addr));
        end

        // Contention from reset: both held high, grants alternate A, B.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        set_req(1'b1, 1'b1, 1'b0, 16'h4005, 16'h0000);
        bad = 0;
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (a_ack !== ((c % 6) == 2) || b_ack !== ((c % 6) == 5)) bad++;
            if (a_ack === 1'b1) check("rr_a_rdata", a_rdata, ref_rd(16'h0010));
            if (b_ack === 1'b1) check("rr_b_rdata", b_rdata, ref_rd(16'h4005));
        end
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0;
        check("rr_ack_pattern", bad, 0);
        $display("txn AB RR 17 cycles, ack pattern errors=%0d", bad);
        repeat (3) @(posedge clk);

        // Reset asserted while an A write is stalled in ISSUE.
        #1;
        set_req(1'b0, 1'b1, 1'b1, 16'h0030, 16'hCAFE);
        mem_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1 check_reset_outputs("mid_rst");
        a_req = 1'b0;
        mem_busy = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_load !== 1'b0 || a_ack !== 1'b0 || b_ack !== 1'b0) bad++;
        end
        check("mid_rst_quiet", bad, 0);
        $display("txn A WR aborted by reset, spurious events=%0d", bad);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port arbiter sharing the single Hack memory bus (RAM / screen VRAM / keyboard map, 1-cycle read latency, VRAM write back-pressure via busy) between requester A (CPU) and requester B (program loader / DMA). It sits directly in front of the memory block. It serialises one transaction at a time, gates writes on the memory busy flag, and returns captured read data with a one-cycle ack pulse.

Parameters:
ADDR_WIDTH, 16, width of requester and memory address buses
DATA_WIDTH, 16, width of write/read data
WDOG_CYCLES, 1024, watchdog limit in cycles of continuous mem_busy (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
a_req  input  1  requester A transaction request; held until a_ack
a_we  input  1  A: 1 = write, 0 = read; stable while a_req
a_addr  input  ADDR_WIDTH  A address; stable while a_req
a_wdata  input  DATA_WIDTH  A write data; stable while a_req
a_ack  output  1  one-cycle pulse: A transaction complete
a_rdata  output  DATA_WIDTH  A read data, valid in the a_ack cycle and held until the next A read
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as A, for requester B
mem_load  output  1  write strobe to memory
mem_address  output  ADDR_WIDTH  memory address
mem_in  output  DATA_WIDTH  memory write data
mem_busy  input  1  memory cannot accept a write this cycle
mem_out  input  DATA_WIDTH  memory read data, valid 1 cycle after address
wdog_err  output  1  sticky watchdog error (optional feature; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_load=0, mem_address=0, mem_in=0, a_ack=b_ack=0, a_rdata=b_rdata=0, wdog_err=0. Last-grant pointer = B, so A wins the first contest.
- IDLE: if exactly one req is high, grant it. If both are high, grant the one not granted last (round-robin). Register we/addr/wdata into mem_* and the owner id. Go to ISSUE. With no req, stay in IDLE with mem_load=0.
- ISSUE, read: mem_address is driven and mem_load=0; mem_busy is ignored. Go to RESP.
- ISSUE, write: if mem_busy=0, assert mem_load for exactly this cycle and go to RESP. If mem_busy=1, mem_load=0 and stay in ISSUE (WAIT). mem_address and mem_in are held constant throughout.
- RESP: pulse the owner's ack for one cycle. On a read, capture mem_out into the owner's rdata in the same edge. The non-owner's rdata is unchanged. Go to IDLE; the pointer is updated to the owner.
- Latency, no contention: req seen at edge 0, ISSUE cycle 1, ack high in cycle 2. Each extra busy cycle adds 1 to write latency. Throughput is at most one transaction per 3 cycles.
- A requester that keeps req high after ack is treated as a new request in IDLE and re-arbitrated, so the other requester cannot starve.
- Dropping req mid-transaction: the transaction still completes and ack still pulses. Requester protocol forbids this.
- Reset asserted mid-transaction: the transaction is aborted immediately, with no mem_load and no ack.
- mem_load is never high outside ISSUE and never while mem_busy=1.

Optional Feature:
MEM_ARB_WATCHDOG_EN
- Defined: a counter increments on each cycle spent in ISSUE with mem_busy=1, and clears when leaving ISSUE. When it reaches WDOG_CYCLES, the write is dropped (no mem_load), the owner still gets ack, and wdog_err is set. wdog_err stays set until reset.
- Undefined: no counter, WAIT lasts indefinitely, and wdog_err is constant 0.

Test Plan:
- A read only, a_addr=0x0010 with memory returning 0x1234 one cycle later -> mem_load never high; a_ack in cycle 2; a_rdata=0x1234; b_ack stays 0.
- B write 0x4005 := 0xBEEF with mem_busy high for 3 cycles -> mem_load one cycle after busy falls; mem_address=0x4005 and mem_in=0xBEEF held throughout; b_ack the following cycle.
- a_req and b_req both held high continuously, first contest from reset -> grants alternate A,B,A,B; each gets an ack every 6 cycles.
- Back-to-back A reads at 0x0001 then 0x0002 (data 0x0011, 0x0022) -> two a_ack pulses 3 cycles apart; a_rdata=0x0011 then 0x0022.
- rst_n pulled low during ISSUE of an A write with mem_busy=1 -> outputs return to reset values at once; no mem_load and no a_ack after release until a new request.
- With MEM_ARB_WATCHDOG_EN and WDOG_CYCLES=8, mem_busy stuck at 1 during a write -> no mem_load; owner ack after 8 WAIT cycles; wdog_err=1 and stays 1.
